// File: rtl/washer_pkg.sv
// ----------------------------------------------------------------------------
// washer_pkg
// Shared definitions for the washing-machine control path.
//   - run_state_t : run-state codes, shared with the mode/time model
//   - PH_*        : phase indices 0..7
//   - FIELD_MSB/LSB : bit positions of each phase duration in the 26-bit
//                     program word (phase 0 sits in the MSBs)
//   - *_MASK      : one bit per phase, set where an actuator is enabled
//   - field_of()  : extracts a phase duration, zero-extended to 4 bits
// ----------------------------------------------------------------------------
package washer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd1,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4,
        ST_PAUSE = 3'd5,
        ST_DONE  = 3'd6
    } run_state_t;

    localparam int PROG_W     = 26;
    localparam int NUM_PHASES = 8;

    localparam logic [2:0] PH_FILL1  = 3'd0;
    localparam logic [2:0] PH_WASH   = 3'd1;
    localparam logic [2:0] PH_DRAIN1 = 3'd2;
    localparam logic [2:0] PH_SPIN1  = 3'd3;
    localparam logic [2:0] PH_FILL2  = 3'd4;
    localparam logic [2:0] PH_RINSE  = 3'd5;
    localparam logic [2:0] PH_DRAIN2 = 3'd6;
    localparam logic [2:0] PH_SPIN2  = 3'd7;

    // Field layout, MSB first: 3,4,3,3,3,4,3,3 bits.
    localparam int FIELD_MSB [NUM_PHASES] = '{25, 22, 18, 15, 12, 9, 5, 2};
    localparam int FIELD_LSB [NUM_PHASES] = '{23, 19, 16, 13, 10, 6, 3, 0};

    localparam logic [7:0] WATER_MASK = (8'd1 << PH_FILL1) | (8'd1 << PH_FILL2);
    localparam logic [7:0] WASH_MASK  = (8'd1 << PH_WASH)  | (8'd1 << PH_RINSE);
    // The drain stays open while spinning, so spin phases appear here too.
    localparam logic [7:0] DRAIN_MASK = (8'd1 << PH_DRAIN1) | (8'd1 << PH_SPIN1) |
                                        (8'd1 << PH_DRAIN2) | (8'd1 << PH_SPIN2);
    localparam logic [7:0] SPIN_MASK  = (8'd1 << PH_SPIN1) | (8'd1 << PH_SPIN2);

    function automatic logic [3:0] field_of(input logic [PROG_W-1:0] w,
                                            input logic [2:0]        idx);
        logic [3:0] sh;
        sh = 4'(w >> FIELD_LSB[idx]);
        if ((FIELD_MSB[idx] - FIELD_LSB[idx]) == 3)
            field_of = sh;
        else
            field_of = {1'b0, sh[2:0]};
    endfunction

endpackage

// File: rtl/phase_skip.sv
// ----------------------------------------------------------------------------
// phase_skip
// Purely combinational search for the next phase with a nonzero duration.
//   prog_reg   in  26 : program word to search
//   cur        in  3  : current phase; search starts strictly after it
//   from_start in  1  : 1 = search from "before phase 0" (initial load)
//   next_phase out 3  : lowest qualifying phase index
//   next_field out 4  : that phase's duration
//   found      out 1  : a qualifying phase exists
// ----------------------------------------------------------------------------
module phase_skip
    import washer_pkg::*;
(
    input  logic [PROG_W-1:0] prog_reg,
    input  logic [2:0]        cur,
    input  logic              from_start,
    output logic [2:0]        next_phase,
    output logic [3:0]        next_field,
    output logic              found
);

    logic [3:0] f;

    // Scan downwards so the lowest qualifying index is the last one written.
    always_comb begin
        next_phase = '0;
        next_field = '0;
        found      = 1'b0;
        f          = '0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            f = field_of(prog_reg, 3'(i));
            if ((from_start || (3'(i) > cur)) && (f != 4'd0)) begin
                found      = 1'b1;
                next_phase = 3'(i);
                next_field = f;
            end
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// ----------------------------------------------------------------------------
// run_sequencer
// Executes a selected washing program: eight phases, each counted down in
// seconds, zero-length phases skipped.
//   cp, rst            : clock, asynchronous active-high reset
//   tick               : 1 Hz one-cycle pulse
//   start              : start button pulse (debounced)
//   pauseBtn           : pulse toggling run/pause
//   lidOpen            : level, 1 = lid open
//   program_word [26]  : phase durations, latched on start
//   runState [3]       : state code (idle 1, run 3, error 4, pause 5, done 6)
//   phase [3], remain [4], total [7] : display data
//   waterValve, washMotor, drainValve, spinMotor : actuators (RUN only)
//   alarm              : high in error and done
// Every output comes from a register (total is arithmetic on registers only),
// so no input reaches an output combinationally.
// ----------------------------------------------------------------------------
module run_sequencer
    import washer_pkg::*;
(
    input  logic              cp,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic              pauseBtn,
    input  logic              lidOpen,
    input  logic [PROG_W-1:0] program_word,
    output logic [2:0]        runState,
    output logic [2:0]        phase,
    output logic [3:0]        remain,
    output logic [6:0]        total,
    output logic              waterValve,
    output logic              washMotor,
    output logic              drainValve,
    output logic              spinMotor,
    output logic              alarm
);

    run_state_t        state, nxt_state;
    logic [PROG_W-1:0] prog_reg, nxt_prog;
    logic [2:0]        nxt_phase;
    logic [3:0]        nxt_remain;

    logic [2:0] init_phase, adv_phase;
    logic [3:0] init_field, adv_field;
    logic       init_found, adv_found;
    logic [6:0] total_sum;

    // Initial load searches the live input word, since prog_reg is only
    // written on the same edge.
    phase_skip u_init_skip (
        .prog_reg   (program_word),
        .cur        (3'd0),
        .from_start (1'b1),
        .next_phase (init_phase),
        .next_field (init_field),
        .found      (init_found)
    );

    phase_skip u_adv_skip (
        .prog_reg   (prog_reg),
        .cur        (phase),
        .from_start (1'b0),
        .next_phase (adv_phase),
        .next_field (adv_field),
        .found      (adv_found)
    );

    // Next-state decode. Priority in RUN: lidOpen, then pauseBtn, then tick,
    // so a tick coinciding with entry into PAUSE or ERROR is dropped.
    always_comb begin
        nxt_state  = state;
        nxt_phase  = phase;
        nxt_remain = remain;
        nxt_prog   = prog_reg;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt_prog = program_word;
                    if (init_found) begin
                        nxt_state  = ST_RUN;
                        nxt_phase  = init_phase;
                        nxt_remain = init_field;
                    end else begin
                        nxt_state  = ST_DONE;
                        nxt_phase  = '0;
                        nxt_remain = '0;
                    end
                end
            end
            ST_RUN: begin
                if (lidOpen) begin
                    nxt_state = ST_ERROR;
                end else if (pauseBtn) begin
                    nxt_state = ST_PAUSE;
                end else if (tick) begin
                    if (remain > 4'd1) begin
                        nxt_remain = remain - 4'd1;
                    end else if (adv_found) begin
                        nxt_phase  = adv_phase;
                        nxt_remain = adv_field;
                    end else begin
                        nxt_state  = ST_DONE;
                        nxt_phase  = '0;
                        nxt_remain = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (lidOpen)
                    nxt_state = ST_ERROR;
                else if (pauseBtn)
                    nxt_state = ST_RUN;
            end
            ST_ERROR: begin
                if (start && !lidOpen)
                    nxt_state = ST_RUN;
            end
            ST_DONE: begin
                if (start)
                    nxt_state = ST_IDLE;
            end
            default: begin
                nxt_state  = ST_IDLE;
                nxt_phase  = '0;
                nxt_remain = '0;
            end
        endcase
    end

    // State and registered outputs. Actuators are decoded from the next
    // state/phase so they line up with the phase they belong to.
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase      <= '0;
            remain     <= '0;
            prog_reg   <= '0;
            waterValve <= 1'b0;
            washMotor  <= 1'b0;
            drainValve <= 1'b0;
            spinMotor  <= 1'b0;
            alarm      <= 1'b0;
        end else begin
            state      <= nxt_state;
            phase      <= nxt_phase;
            remain     <= nxt_remain;
            prog_reg   <= nxt_prog;
            waterValve <= (nxt_state == ST_RUN) && WATER_MASK[nxt_phase];
            washMotor  <= (nxt_state == ST_RUN) && WASH_MASK[nxt_phase];
            drainValve <= (nxt_state == ST_RUN) && DRAIN_MASK[nxt_phase];
            spinMotor  <= (nxt_state == ST_RUN) && SPIN_MASK[nxt_phase];
            alarm      <= (nxt_state == ST_ERROR) || (nxt_state == ST_DONE);
        end
    end

    assign runState = state;

    // Time left in the program: current count plus every later field.
    // Only meaningful while a program is in progress; reads 0 otherwise.
    always_comb begin
        total_sum = 7'(remain);
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (3'(i) > phase)
                total_sum = total_sum + 7'(field_of(prog_reg, 3'(i)));
        end
        if ((state == ST_RUN) || (state == ST_PAUSE) || (state == ST_ERROR))
            total = total_sum;
        else
            total = '0;
    end

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

  logic        cp = 1'b0;
  logic        rst;
  logic        tick, start, pauseBtn, lidOpen;
  logic [25:0] program_word;
  logic [2:0]  runState, phase;
  logic [3:0]  remain;
  logic [6:0]  total;
  logic        waterValve, washMotor, drainValve, spinMotor, alarm;

  run_sequencer dut (
    .cp           (cp),
    .rst          (rst),
    .tick         (tick),
    .start        (start),
    .pauseBtn     (pauseBtn),
    .lidOpen      (lidOpen),
    .program_word (program_word),
    .runState     (runState),
    .phase        (phase),
    .remain       (remain),
    .total        (total),
    .waterValve   (waterValve),
    .washMotor    (washMotor),
    .drainValve   (drainValve),
    .spinMotor    (spinMotor),
    .alarm        (alarm)
  );

  // ---------------- clock ----------------
  always #5 cp = ~cp;

  localparam logic [25:0] FULL_PROG = 26'b011_1010_100_101_011_1000_100_101;
  localparam logic [25:0] SKIP_PROG = 26'b000_0000_000_000_000_0000_100_101;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  bit lid_lvl  = 1'b0;

  // ---------------- behavioural model ----------------
  // State held as the run-state code itself; durations as a plain array.
  int m_st, m_ph, m_rem;
  int m_dur [8];

  function automatic int dur_of(input logic [25:0] w, input int i);
    int widths [8] = '{3, 4, 3, 3, 3, 4, 3, 3};
    int lsb = 0;
    for (int k = 7; k > i; k--) lsb += widths[k];
    return int'((w >> lsb) & ((26'd1 << widths[i]) - 26'd1));
  endfunction

  function automatic int first_nz_after(input int from);
    for (int k = from + 1; k < 8; k++)
      if (m_dur[k] != 0) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_st = 1; m_ph = 0; m_rem = 0;
    for (int k = 0; k < 8; k++) m_dur[k] = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit p, input bit l,
                            input logic [25:0] w);
    int n;
    case (m_st)
      1: if (s) begin
           for (int k = 0; k < 8; k++) m_dur[k] = dur_of(w, k);
           n = first_nz_after(-1);
           if (n >= 0) begin m_st = 3; m_ph = n; m_rem = m_dur[n]; end
           else begin m_st = 6; m_ph = 0; m_rem = 0; end
         end
      3: if (l) m_st = 4;
         else if (p) m_st = 5;
         else if (t) begin
           if (m_rem > 1) m_rem = m_rem - 1;
           else begin
             n = first_nz_after(m_ph);
             if (n >= 0) begin m_ph = n; m_rem = m_dur[n]; end
             else begin m_st = 6; m_ph = 0; m_rem = 0; end
           end
         end
      5: if (l) m_st = 4; else if (p) m_st = 3;
      4: if (s && !l) m_st = 3;
      6: if (s) m_st = 1;
      default: m_st = 1;
    endcase
  endtask

  function automatic int exp_total();
    int sum;
    if (!(m_st == 3 || m_st == 4 || m_st == 5)) return 0;
    sum = m_rem;
    for (int k = m_ph + 1; k < 8; k++) sum += m_dur[k];
    return sum;
  endfunction

  function automatic int in_run();
    return (m_st == 3) ? 1 : 0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge cp) begin
    if (!rst && cmp_en) begin
      check("runState", int'(runState), m_st);
      check("phase",    int'(phase),    m_ph);
      check("remain",   int'(remain),   m_rem);
      check("total",    int'(total),    exp_total());
      check("waterValve", int'(waterValve), in_run() & ((m_ph == 0 || m_ph == 4) ? 1 : 0));
      check("washMotor",  int'(washMotor),  in_run() & ((m_ph == 1 || m_ph == 5) ? 1 : 0));
      check("drainValve", int'(drainValve), in_run() & ((m_ph == 2 || m_ph == 3 || m_ph == 6 || m_ph == 7) ? 1 : 0));
      check("spinMotor",  int'(spinMotor),  in_run() & ((m_ph == 3 || m_ph == 7) ? 1 : 0));
      check("alarm",      int'(alarm),      (m_st == 4 || m_st == 6) ? 1 : 0);
    end
  end

  // ---------------- driver ----------------
  task automatic cycle(input bit t, input bit s, input bit p);
    tick = t; start = s; pauseBtn = p; lidOpen = lid_lvl;
    @(posedge cp);
    #1;
    model_step(t, s, p, lid_lvl, program_word);
    @(negedge cp);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  int act_sum;
  int ph_cnt [8];
  int exp_len [8] = '{3, 10, 4, 5, 3, 8, 4, 5};

  initial begin
    rst = 1'b1; tick = 0; start = 0; pauseBtn = 0; lidOpen = 0;
    program_word = '0;
    model_reset();
    #2;
    check("rst_runState", int'(runState), 1);
    check("rst_phase",    int'(phase), 0);
    check("rst_remain",   int'(remain), 0);
    check("rst_total",    int'(total), 0);
    act_sum = int'(waterValve) + int'(washMotor) + int'(drainValve) + int'(spinMotor) + int'(alarm);
    check("rst_outputs",  act_sum, 0);
    @(negedge cp);
    rst = 1'b0;
    cmp_en = 1'b1;
    cycle(0, 0, 0);

    // Full program, continuous ticks.
    program_word = FULL_PROG;
    cycle(0, 1, 0);
    program_word = ~FULL_PROG;
    check("full_total0", int'(total), 42);
    check("full_phase0", int'(phase), 0);
    check("full_remain0", int'(remain), 3);
    check("full_water0", int'(waterValve), 1);
    for (int k = 0; k < 8; k++) ph_cnt[k] = 0;
    for (int k = 1; k <= 42; k++) begin
      if (runState == 3'd3) ph_cnt[phase] = ph_cnt[phase] + 1;
      cycle(1, 0, 0);
      check("full_total_step", int'(total), 42 - k);
    end
    for (int k = 0; k < 8; k++) check("full_phase_len", ph_cnt[k], exp_len[k]);
    check("full_done_state", int'(runState), 6);
    check("full_done_alarm", int'(alarm), 1);
    cycle(0, 1, 0);
    check("done_to_idle", int'(runState), 1);

    // Zero phases skipped.
    program_word = SKIP_PROG;
    cycle(0, 1, 0);
    check("skip_phase6", int'(phase), 6);
    check("skip_drain", int'(drainValve), 1);
    ticks(4);
    check("skip_phase7", int'(phase), 7);
    check("skip_spin", int'(spinMotor), 1);
    ticks(5);
    check("skip_done", int'(runState), 6);
    cycle(0, 1, 0);

    // Pause during wash at remain 6.
    program_word = FULL_PROG;
    cycle(0, 1, 0);
    ticks(7);
    check("pause_pre_remain", int'(remain), 6);
    cycle(0, 0, 1);
    program_word = 26'($urandom);
    check("pause_state", int'(runState), 5);
    act_sum = int'(waterValve) + int'(washMotor) + int'(drainValve) + int'(spinMotor);
    check("pause_actuators", act_sum, 0);
    ticks(5);
    check("pause_frozen", int'(remain), 6);
    cycle(0, 0, 1);
    check("resume_wash", int'(washMotor), 1);
    check("resume_remain", int'(remain), 6);

    // Lid open at phase 3 (tick in the same cycle is dropped).
    ticks(11);
    check("lid_pre_phase", int'(phase), 3);
    check("lid_pre_remain", int'(remain), 4);
    lid_lvl = 1'b1;
    cycle(1, 0, 0);
    check("lid_error", int'(runState), 4);
    check("lid_alarm", int'(alarm), 1);
    check("lid_remain", int'(remain), 4);
    cycle(0, 1, 0);
    check("lid_start_ignored", int'(runState), 4);
    lid_lvl = 1'b0;
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    check("lid_resume_state", int'(runState), 3);
    check("lid_resume_phase", int'(phase), 3);
    check("lid_resume_remain", int'(remain), 4);

    // tick + pauseBtn together.
    cycle(1, 0, 1);
    check("coinc_pause", int'(runState), 5);
    check("coinc_remain", int'(remain), 4);
    cycle(0, 0, 1);
    cycle(1, 0, 0);

    // Asynchronous reset mid-spin.
    check("spin_before_rst", int'(spinMotor), 1);
    cmp_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    act_sum = int'(waterValve) + int'(washMotor) + int'(drainValve) + int'(spinMotor) + int'(alarm);
    check("async_rst_outputs", act_sum, 0);
    check("async_rst_state", int'(runState), 1);
    check("async_rst_remain", int'(remain), 0);
    model_reset();
    @(negedge cp);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Empty program.
    program_word = '0;
    cycle(0, 1, 0);
    check("empty_done", int'(runState), 6);
    check("empty_alarm", int'(alarm), 1);
    cycle(0, 1, 0);

    // Randomized run against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [25:0] w;
      w = 26'($urandom);
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 2) == 0) w = w & ~(26'd15 << (k * 3));
      end
      program_word = w;
      if ($urandom_range(0, 39) == 0) lid_lvl = ~lid_lvl;
      cycle(bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 7) == 0),
            bit'($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Executes a washing program once it has been selected. Latches the 26-bit phase-duration word produced by the mode/time model at start. Steps through the eight program phases, decrementing a per-phase counter on each 1 Hz tick and skipping phases of zero duration. Drives the water valve, drain valve and motor actuators, and reports the run state, phase and remaining time to the display path. Handles pause, lid-open error and finish.

## Interface
- No parameters. Widths are fixed by the 26-bit program word.
- `cp` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `tick` in 1: one-cycle pulse, once per second, synchronous to `cp`.
- `start` in 1: one-cycle pulse from the start button, already debounced.
- `pauseBtn` in 1: one-cycle pulse that toggles between run and pause.
- `lidOpen` in 1: level; 1 means the lid is open.
- `program` in 26: phase durations, in seconds. The fields, MSB first, are:
  - phase 0, fill1, 3 bits
  - phase 1, wash, 4 bits
  - phase 2, drain1, 3 bits
  - phase 3, spin1, 3 bits
  - phase 4, fill2, 3 bits
  - phase 5, rinse, 4 bits
  - phase 6, drain2, 3 bits
  - phase 7, spin2, 3 bits
- `runState` out 3: 1 = idle, 3 = run, 4 = error, 5 = pause, 6 = finish.
- `phase` out 3: index of the current phase. Valid in run, pause and error.
- `remain` out 4: seconds left in the current phase.
- `total` out 7: seconds left in the whole program. Equals `remain` plus all later phase fields. Maximum value is 72.
- `waterValve`, `washMotor`, `drainValve`, `spinMotor` out 1 each: actuator enables.
- `alarm` out 1: high in error and finish.

## Operation
- **States:** IDLE, RUN, PAUSE, ERROR, DONE.
- **IDLE, on `start`:**
  - Latch `program` into `progReg`.
  - Load the first phase p with a nonzero field, and set `remain` to field(p); go to RUN.
  - If all fields are 0, go directly to DONE.
- **RUN, on `tick`:**
  - If `remain` is greater than 1, decrement it.
  - If `remain` is 1, advance to the next nonzero phase q > `phase` and load `remain` with field(q).
  - If no such q exists, go to DONE, clear `phase`, and set `remain` to 0.
- **RUN, on `pauseBtn`:** go to PAUSE.
- **PAUSE:**
  - Ticks are ignored; `remain` and `phase` are frozen.
  - `pauseBtn` returns the block to RUN.
- **Lid open:** `lidOpen` = 1 in RUN or PAUSE sends the block to ERROR; `phase` and `remain` are frozen.
- **ERROR:** `start` with `lidOpen` = 0 resumes RUN at the same phase and count. `start` with `lidOpen` = 1 is ignored.
- **DONE:** `start` goes to IDLE.
- **Priority, when inputs coincide in the same cycle:** `lidOpen`, then `pauseBtn`, then `tick`.
  - A tick that coincides with an entry into PAUSE or ERROR is dropped.
- **Ignored inputs:**
  - `start` in RUN and PAUSE.
  - `pauseBtn` in IDLE, ERROR and DONE.
  - `lidOpen` in IDLE and DONE.
- **Actuators:** active only in RUN.
  - `waterValve`: phases 0 and 4.
  - `washMotor`: phases 1 and 5.
  - `drainValve`: phases 2, 3, 6 and 7; it stays open during spin.
  - `spinMotor`: phases 3 and 7.
  - All actuators are 0 in PAUSE, ERROR, IDLE and DONE.
- **Program latching:** `program` changes after start have no effect; only `progReg` is used.

## Timing
- **Reset values:**
  - State IDLE; `runState` = 1.
  - `phase` = 0, `remain` = 0, `progReg` = 0, `total` = 0.
  - All actuators and `alarm` = 0.
- **Reset mid-run:** returns to IDLE immediately; actuators drop asynchronously.
- **Latency:** all outputs are decoded from registers. Changes appear in the cycle after the triggering edge. There is no combinational path from any input to any output.
- **Start:** actuators for the first phase assert one cycle after the `start` pulse.
- **Phase length:** a phase of duration d lasts exactly d ticks in RUN.
- **`total` arithmetic:** computed combinationally from `remain` and `progReg`. Zero-extend each field to 7 bits; no overflow is possible.

## Structure
- **Package `washer_pkg`:**
  - State codes 1 (idle), 3, 4, 5 and 6, shared with the mode model.
  - Phase indices 0–7.
  - Field MSB/LSB positions for the 26-bit word.
  - Actuator phase masks.
- **Sub-module `phase_skip`:**
  - Inputs: `progReg` and a current index.
  - Outputs: next nonzero phase index, that phase's field value, and a `found` flag. Purely combinational.
  - Also used for the initial load, with "before phase 0" as the search start.

## Test plan
- **Full wash/rinse/dry program:**
  - Stimulus: `program` = 011_1010_100_101_011_1000_100_101, `start`, continuous ticks.
  - Required response: phases 0–7 last 3, 10, 4, 5, 3, 8, 4 and 5 ticks. `total` starts at 42 and decreases by 1 per tick. DONE after 42 ticks, with `alarm` = 1 and `runState` = 6.
- **Skipping zero phases:**
  - Stimulus: `program` = 000_0000_000_000_000_0000_100_101.
  - Required response: first phase is 6 with `drainValve` = 1; then phase 7 with `spinMotor` = 1; DONE after 9 ticks.
- **Pause:**
  - Stimulus: `pauseBtn` during wash with `remain` = 6, then 5 ticks, then `pauseBtn`.
  - Required response: `runState` = 5, all actuators 0, `remain` stays 6. After resume, `washMotor` = 1 and `remain` = 6.
- **Lid open:**
  - Stimulus: `lidOpen` = 1 in RUN at phase 3.
  - Required response: ERROR, `alarm` = 1.
  - Stimulus: `start` while the lid is still open.
  - Required response: ignored.
  - Stimulus: lid closed, then `start`.
  - Required response: RUN at phase 3 with the same `remain`.
- **Coincident inputs and empty program:**
  - Stimulus: `tick` and `pauseBtn` in the same cycle.
  - Required response: PAUSE, `remain` unchanged.
  - Stimulus: all-zero `program`, then `start`.
  - Required response: DONE on the next cycle.
- **Reset mid-operation:**
  - Stimulus: `rst` asserted mid-spin.
  - Required response: all outputs 0 and `runState` = 1 without waiting for a `cp` edge.
